// File: rtl/opentrig_pkg.sv
// Shared definitions for the reference-clock/reset link: the timestamp width default,
// the transmitter FSM states and the timestamp type.
package opentrig_pkg;

  localparam int REF_W_DEF = 48;

  typedef enum logic [1:0] {
    SYNC_HOLD = 2'd0,
    SETUP     = 2'd1,
    RUN       = 2'd2
  } state_t;

  typedef logic [REF_W_DEF-1:0] ref_t;

endpackage

// File: rtl/ref_edge_counter.sv
// Edge counter split into two W/2 halves. The carry into the high half is registered, so the
// high half updates one cycle after the low half wraps.
module ref_edge_counter #(
  parameter int W = 48
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_incr,
  output logic [W-1:0] o_value
);

  localparam int HW = W / 2;

  logic [HW-1:0] r_lo;
  logic [HW-1:0] r_hi;
  logic          r_carry;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lo    <= '0;
      r_hi    <= '0;
      r_carry <= 1'b0;
    end else if (i_clear) begin
      r_lo    <= '0;
      r_hi    <= '0;
      r_carry <= 1'b0;
    end else begin
      r_carry <= i_incr && (r_lo == '1);
      if (i_incr) r_lo <= r_lo + 1'b1;
      if (r_carry) r_hi <= r_hi + 1'b1;
    end
  end

  assign o_value = {r_hi, r_lo};

endmodule

// File: rtl/clk_ref_gen.sv
// Reference clock/reset transmitter: holds reset_out, waits the setup time, then divides
// sampling_clk into clk_out while mirroring the timestamp each receiver latches.
module clk_ref_gen
  import opentrig_pkg::*;
#(
  parameter int HALF_PERIOD  = 50,
  parameter int RESET_CYCLES = 16,
  parameter int SETUP_CYCLES = 8,
  parameter int REF_W        = REF_W_DEF
) (
  input  logic             sampling_clk,
  input  logic             reset_n,
  input  logic             sync_req,
  output logic             sync_ack,
  input  logic             run_en,
  output logic             clk_out,
  output logic             reset_out,
  output logic [REF_W-1:0] tx_ref,
  output logic             tx_ref_valid,
  output logic             running,
  output state_t           dbg_state
);

  // Handshake: sync_req is a level held by the requester; sync_ack is a one-cycle pulse on
  // the first clk_out rising edge after the resync, and the requester drops sync_req on it.

  localparam int CW = 16;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_phase;
  logic             r_parked;
  logic             r_running;
  logic             r_clk_out;
  logic             r_reset_out;
  logic             r_sync_ack;
  logic             r_ack_pend;
  logic             r_valid;
  logic [REF_W-1:0] r_tx_ref;

  logic             w_rise;
  logic             w_clear;
  logic             w_hold_done;
  logic             w_setup_done;
  logic             w_phase_wrap;
  logic [REF_W-1:0] w_edge_cnt;

  assign w_hold_done  = (r_cnt == CW'(RESET_CYCLES - 1));
  assign w_setup_done = (r_cnt == CW'(SETUP_CYCLES - 1));
  assign w_phase_wrap = (r_phase == CW'(HALF_PERIOD - 1));

  // A resync request beats a coincident phase wrap, so no edge is emitted that cycle.
  always_comb begin
    w_rise  = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      SETUP: w_rise = w_setup_done && run_en;
      RUN: begin
        if (sync_req)      w_clear = 1'b1;
        else if (r_parked) w_rise  = run_en;
        else               w_rise  = w_phase_wrap && !r_clk_out && run_en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sampling_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SYNC_HOLD;
      r_cnt       <= '0;
      r_phase     <= '0;
      r_parked    <= 1'b0;
      r_running   <= 1'b0;
      r_clk_out   <= 1'b0;
      r_reset_out <= 1'b1;
      r_sync_ack  <= 1'b0;
      r_ack_pend  <= 1'b1;
      r_valid     <= 1'b0;
      r_tx_ref    <= '0;
    end else begin
      r_sync_ack <= 1'b0;
      r_valid    <= 1'b0;
      case (r_state)
        SYNC_HOLD: begin
          if (w_hold_done) begin
            r_state     <= SETUP;
            r_cnt       <= '0;
            r_reset_out <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SETUP: begin
          if (w_setup_done) begin
            r_state   <= RUN;
            r_phase   <= '0;
            r_parked  <= !run_en;
            r_running <= run_en;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (sync_req) begin
            r_state     <= SYNC_HOLD;
            r_cnt       <= '0;
            r_phase     <= '0;
            r_clk_out   <= 1'b0;
            r_reset_out <= 1'b1;
            r_parked    <= 1'b0;
            r_running   <= 1'b0;
            r_ack_pend  <= 1'b1;
          end else if (r_parked) begin
            if (run_en) begin
              r_parked  <= 1'b0;
              r_running <= 1'b1;
            end
          end else if (w_phase_wrap) begin
            r_phase <= '0;
            if (r_clk_out) r_clk_out <= 1'b0;
            // The falling edge is the phase boundary where a disabled clock parks.
            if (!run_en) begin
              r_parked  <= 1'b1;
              r_running <= 1'b0;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: r_state <= SYNC_HOLD;
      endcase
      if (w_rise) begin
        r_clk_out <= 1'b1;
        r_tx_ref  <= w_edge_cnt;
        r_valid   <= 1'b1;
        if (r_ack_pend) begin
          r_sync_ack <= 1'b1;
          r_ack_pend <= 1'b0;
        end
      end
    end
  end

  ref_edge_counter #(
    .W(REF_W)
  ) u_edge_cnt (
    .i_clk   (sampling_clk),
    .i_rst_n (reset_n),
    .i_clear (w_clear),
    .i_incr  (w_rise),
    .o_value (w_edge_cnt)
  );

  assign sync_ack     = r_sync_ack;
  assign clk_out      = r_clk_out;
  assign reset_out    = r_reset_out;
  assign tx_ref       = r_tx_ref;
  assign tx_ref_valid = r_valid;
  assign running      = r_running;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_clk_ref_gen.sv
// Bench for clk_ref_gen: directed timing checks plus randomized run/pause/resync traffic
// checked against a receiver model (edge count since reset_out fell) and a small-width wrap instance.
module tb_clk_ref_gen;
  import opentrig_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   reset_n  = 1'b0;
  logic   rst1_n   = 1'b0;
  logic   sync_req = 1'b0;
  logic   run_en   = 1'b1;
  logic   sync_ack, clk_out, reset_out, tx_ref_valid, running;
  ref_t   tx_ref;
  state_t dbg_state;

  logic       sync_ack1, clk_out1, reset_out1, tx_ref_valid1, running1;
  logic [7:0] tx_ref1;
  state_t     dbg_state1;

  clk_ref_gen #(
    .HALF_PERIOD(4), .RESET_CYCLES(16), .SETUP_CYCLES(8), .REF_W(48)
  ) dut (
    .sampling_clk(clk), .reset_n(reset_n), .sync_req(sync_req), .sync_ack(sync_ack),
    .run_en(run_en), .clk_out(clk_out), .reset_out(reset_out), .tx_ref(tx_ref),
    .tx_ref_valid(tx_ref_valid), .running(running), .dbg_state(dbg_state)
  );

  clk_ref_gen #(
    .HALF_PERIOD(2), .RESET_CYCLES(4), .SETUP_CYCLES(2), .REF_W(8)
  ) dut_w8 (
    .sampling_clk(clk), .reset_n(rst1_n), .sync_req(1'b0), .sync_ack(sync_ack1),
    .run_en(1'b1), .clk_out(clk_out1), .reset_out(reset_out1), .tx_ref(tx_ref1),
    .tx_ref_valid(tx_ref_valid1), .running(running1), .dbg_state(dbg_state1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard: receiver model ----------------
  logic [47:0] exp_q[$];
  logic [47:0] rx_cnt   = '0;
  logic        rx_first = 1'b0;
  logic        p_clk    = 1'b0;
  logic        p_rst    = 1'b1;
  int          n_rise   = 0;
  int          n_ack    = 0;

  always @(negedge clk) begin
    logic rise;
    rise = clk_out && !p_clk;
    if (p_rst && !reset_out) begin
      rx_cnt   = '0;
      rx_first = 1'b1;
    end
    if (sync_ack) n_ack++;
    if (rise) begin
      exp_q.push_back(rx_cnt);
      rx_cnt = rx_cnt + 1'b1;
      check("sync_ack_on_rise", sync_ack, rx_first);
      rx_first = 1'b0;
      n_rise++;
    end else if (sync_ack) begin
      check("sync_ack_stray", 1'b1, 1'b0);
    end
    if (tx_ref_valid) begin
      if (exp_q.size() == 0) check("valid_without_rise", 1'b1, 1'b0);
      else                   check("tx_ref", tx_ref, exp_q.pop_front());
    end
    if (exp_q.size() != 0) begin
      check("rise_without_valid", 1'b0, 1'b1);
      exp_q.delete();
    end
    p_clk = clk_out;
    p_rst = reset_out;
  end

  // Narrow instance: every rise must carry the 8-bit edge count, wrapping 0xFF -> 0x00.
  logic [7:0] rx1      = '0;
  logic       p_clk1   = 1'b0;
  logic       p_rst1   = 1'b1;
  int         wraps1   = 0;

  always @(negedge clk) begin
    if (p_rst1 && !reset_out1) rx1 = '0;
    if (clk_out1 && !p_clk1) begin
      check("w8_valid", tx_ref_valid1, 1'b1);
      check("w8_tx_ref", tx_ref1, rx1);
      if (rx1 == 8'hFF) wraps1++;
      rx1 = rx1 + 1'b1;
    end
    p_clk1 = clk_out1;
    p_rst1 = reset_out1;
  end

  // ---------------- driver tasks ----------------
  // which: 0 reset_out low, 1 clk_out rising, 2 clk_out low, 3 sync_ack high
  task automatic wait_cond(input int which, input int budget, output int n);
    logic pc;
    logic hit;
    pc  = clk_out;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = !reset_out;
        1:       hit = clk_out && !pc;
        2:       hit = !clk_out;
        default: hit = sync_ack;
      endcase
      pc = clk_out;
    end
    if (!hit) check("wait_timeout", 64'(which), 64'hFF);
  endtask

  task automatic check_reset_vals();
    check("rst_clk_out", clk_out, 1'b0);
    check("rst_reset_out", reset_out, 1'b1);
    check("rst_sync_ack", sync_ack, 1'b0);
    check("rst_tx_ref", tx_ref, 48'd0);
    check("rst_valid", tx_ref_valid, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_state", 64'(dbg_state), 64'(SYNC_HOLD));
  endtask

  task automatic do_sync();
    int n;
    sync_req = 1'b1;
    wait_cond(3, 300, n);
    sync_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int a0;
    int target;
    int viol;
    ref_t last_ref;

    repeat (3) @(negedge clk);
    check_reset_vals();
    reset_n = 1'b1;
    rst1_n  = 1'b1;

    // power-up sync
    wait_cond(0, 100, n);
    check("t1_reset_hold", n, 16);
    wait_cond(1, 100, n);
    check("t1_setup_len", n, 8);
    check("t1_first_ref", tx_ref, 48'd0);
    check("t1_first_valid", tx_ref_valid, 1'b1);
    check("t1_first_ack", sync_ack, 1'b1);
    check("t1_running", running, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_cond(1, 100, n);
      check("t1_period", n, 8);
    end

    // resync during the high phase
    wait_cond(1, 100, n);
    @(negedge clk);
    a0 = n_ack;
    sync_req = 1'b1;
    @(negedge clk);
    check("t4_clk_forced_low", clk_out, 1'b0);
    check("t4_reset_out_high", reset_out, 1'b1);
    wait_cond(0, 100, n);
    check("t4_reset_hold", n, 16);
    wait_cond(3, 100, n);
    check("t4_ack_delay", n, 8);
    check("t4_ref_restart", tx_ref, 48'd0);
    sync_req = 1'b0;
    repeat (2) wait_cond(1, 100, n);
    check("t4_one_ack", n_ack - a0, 1);

    // park mid-high-phase, then resume
    wait_cond(1, 100, n);
    check("t5_running_before", running, 1'b1);
    run_en = 1'b0;
    wait_cond(2, 100, n);
    check("t5_high_completed", n, 4);
    check("t5_running_parked", running, 1'b0);
    last_ref = tx_ref;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (clk_out || tx_ref_valid || running) viol++;
    end
    check("t5_parked_quiet", viol, 0);
    run_en = 1'b1;
    @(negedge clk);
    check("t5_resume_rise", clk_out, 1'b1);
    check("t5_resume_valid", tx_ref_valid, 1'b1);
    check("t5_no_gap", tx_ref, last_ref + 1'b1);
    check("t5_running_resumed", running, 1'b1);

    // async reset in RUN, then in SETUP
    repeat (5) wait_cond(1, 100, n);
    #2 reset_n = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    wait_cond(0, 100, n);
    check("t6_run_reset_hold", n, 16);
    repeat (3) @(negedge clk);
    check("t6_in_setup", 64'(dbg_state), 64'(SETUP));
    #2 reset_n = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    wait_cond(0, 100, n);
    check("t6_setup_reset_hold", n, 16);
    wait_cond(1, 100, n);
    check("t6_setup_len", n, 8);
    check("t6_ref_zero", tx_ref, 48'd0);

    // randomized run / pause / resync traffic
    target = n_rise + 2000;
    while (n_rise < target) begin
      int pick;
      pick = $urandom_range(0, 99);
      if (pick < 3) begin
        do_sync();
      end else if (pick < 15) begin
        run_en = 1'b0;
        repeat ($urandom_range(1, 12)) @(negedge clk);
        run_en = 1'b1;
      end else begin
        wait_cond(1, 100, n);
      end
    end

    repeat (5) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("w8_wrapped", wraps1 > 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
